// File: rtl/rr_onehot_encoder.sv
// Round-robin selector over an 8-line request vector. The chosen line is
// presented as a registered one-hot grant plus its binary index, behind a valid/ready handshake.
module rr_onehot_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [7:0]       grant,
    output logic [2:0]       idx,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state;
    logic [2:0] ptr;
    logic [2:0] scan_base;
    logic [2:0] sel_idx;
    logic       xfer;

    // First set bit of r, scanning upward from p and wrapping modulo 8.
    function automatic logic [2:0] rr_sel(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] s;
        logic [2:0] j;
        s = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            j = p + 3'(i);
            if (r[j]) s = j;
        end
        return s;
    endfunction

    assign xfer      = (state == BUSY) && out_ready;
    // On a completing transfer the next pick must already see the advanced pointer.
    assign scan_base = xfer ? idx + 3'd1 : ptr;
    assign sel_idx   = rr_sel(req, scan_base);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            out_valid <= 1'b0;
            grant     <= 8'h00;
            idx       <= 3'd0;
            xfer_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 8'h00) begin
                        grant     <= 8'd1 << sel_idx;
                        idx       <= sel_idx;
                        out_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Grant is locked until the consumer takes it; req changes are ignored.
                    if (out_ready) begin
                        xfer_cnt <= xfer_cnt + CNT_W'(1);
                        ptr      <= idx + 3'd1;
                        if (req != 8'h00) begin
                            grant <= 8'd1 << sel_idx;
                            idx   <= sel_idx;
                        end else begin
                            grant     <= 8'h00;
                            idx       <= 3'd0;
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    grant     <= 8'h00;
                    idx       <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onehot_encoder.sv
// Directed bench for rr_onehot_encoder. A second instance with CNT_W=2
// shares the same stimulus so that counter wrap can be observed.
module tb_rr_onehot_encoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  grant;
    logic [2:0]  idx;
    logic [15:0] xfer_cnt;
    logic        out_valid2;
    logic [7:0]  grant2;
    logic [2:0]  idx2;
    logic [1:0]  xfer_cnt2;

    int checks = 0;
    int errors = 0;

    rr_onehot_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(out_valid), .grant(grant), .idx(idx), .xfer_cnt(xfer_cnt)
    );

    rr_onehot_encoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(out_valid2), .grant(grant2), .idx(idx2), .xfer_cnt(xfer_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs are changed after this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released between edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'h00; out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || grant !== 8'h00 || idx !== 3'd0 || xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold: v=%b g=%h i=%0d c=%0d want 0 00 0 0", out_valid, grant, idx, xfer_cnt);
        end
        #3 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || grant !== 8'h00 || idx !== 3'd0 || xfer_cnt !== 16'd0) begin
                errors++;
                $display("FAIL idle_c%0d: v=%b g=%h i=%0d c=%0d want 0 00 0 0", c, out_valid, grant, idx, xfer_cnt);
            end
        end
    endtask

    task automatic test_onehot();
        logic [7:0] exp_g;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_g = 8'h01 << k;
            req = exp_g;
            step();
            checks++;
            if (out_valid !== 1'b1 || grant !== exp_g || idx !== 3'(k)) begin
                errors++;
                $display("FAIL onehot_k%0d: v=%b g=%h i=%0d want 1 %h %0d", k, out_valid, grant, idx, exp_g, k);
            end
            req = 8'h00;
            step();
            checks++;
            if (out_valid !== 1'b0 || grant !== 8'h00 || idx !== 3'd0) begin
                errors++;
                $display("FAIL onehot_idle_k%0d: v=%b g=%h i=%0d want 0 00 0", k, out_valid, grant, idx);
            end
        end
        checks++;
        if (xfer_cnt !== 16'd8) begin
            errors++;
            $display("FAIL onehot_cnt: got %0d want 8", xfer_cnt);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_i [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        logic [7:0] exp_g;
        req = 8'hFF; out_ready = 1'b1;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step();
            exp_g = 8'h01 << exp_i[n];
            checks++;
            if (out_valid !== 1'b1 || idx !== exp_i[n] || grant !== exp_g || xfer_cnt !== 16'(n)) begin
                errors++;
                $display("FAIL fair_n%0d: v=%b i=%0d g=%h c=%0d want 1 %0d %h %0d",
                         n, out_valid, idx, grant, xfer_cnt, exp_i[n], exp_g, n);
            end
        end
    endtask

    task automatic test_stall();
        req = 8'b0010_0100; out_ready = 1'b0;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || idx !== 3'd2 || grant !== 8'h04 || xfer_cnt !== 16'd0) begin
                errors++;
                $display("FAIL stall_n%0d: v=%b i=%0d g=%h c=%0d want 1 2 04 0", n, out_valid, idx, grant, xfer_cnt);
            end
            req = 8'b0010_0000;
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || idx !== 3'd5 || grant !== 8'h20 || xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stall_release: v=%b i=%0d g=%h c=%0d want 1 5 20 1", out_valid, idx, grant, xfer_cnt);
        end
        req = 8'h00;
        step();
        checks++;
        if (out_valid !== 1'b0 || grant !== 8'h00 || xfer_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stall_drain: v=%b g=%h c=%0d want 0 00 2", out_valid, grant, xfer_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_i [3] = '{3'd0, 3'd7, 3'd0};
        req = 8'b1000_0001; out_ready = 1'b1;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || idx !== exp_i[n] || grant !== (8'h01 << exp_i[n])) begin
                errors++;
                $display("FAIL b2b_n%0d: v=%b i=%0d g=%h want 1 %0d", n, out_valid, idx, grant, exp_i[n]);
            end
        end
    endtask

    task automatic test_reset_mid();
        req = 8'hFF; out_ready = 1'b1;
        do_reset();
        for (int n = 0; n < 4; n++) step();
        checks++;
        if (idx !== 3'd3) begin
            errors++;
            $display("FAIL mid_pre: idx=%0d want 3", idx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || grant !== 8'h00 || idx !== 3'd0 || xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_clear: v=%b g=%h i=%0d c=%0d want 0 00 0 0", out_valid, grant, idx, xfer_cnt);
        end
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || idx !== 3'd0 || grant !== 8'h01 || xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_restart: v=%b i=%0d g=%h c=%0d want 1 0 01 0", out_valid, idx, grant, xfer_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        req = 8'hFF; out_ready = 1'b1;
        do_reset();
        step();
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (xfer_cnt2 !== exp_c[n] || xfer_cnt !== 16'(n + 1)) begin
                errors++;
                $display("FAIL wrap_n%0d: c2=%0d c16=%0d want %0d %0d", n, xfer_cnt2, xfer_cnt, exp_c[n], n + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_fairness();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
